// File: rtl/ddr4_arb_pkg.sv
// rtl/ddr4_arb_pkg.sv - shared types for the two-requester DDR4 bank arbiter
package ddr4_arb_pkg;

    localparam int MAX_BURST = 4;
    localparam int TAG_LEN_W = 3;

    typedef logic arb_id_t;

    typedef struct packed {
        arb_id_t              id;
        logic [TAG_LEN_W-1:0] len;
    } rsp_tag_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_WLOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ddr4_arb_rsp_fifo.sv
// rtl/ddr4_arb_rsp_fifo.sv - show-ahead tag FIFO tracking outstanding read commands
module ddr4_arb_rsp_fifo
    import ddr4_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  rsp_tag_t push_tag,
    input  logic     pop,
    output rsp_tag_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    rsp_tag_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_tag;
    end

    // Flags come from the next count so they are registered, never combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/ddr4_bank_arbiter.sv
// rtl/ddr4_bank_arbiter.sv - round-robin Avalon-MM arbiter for one DDR4 bank
// Optional DDR4_ARB_PERF_EN adds per-requester grant counters and a sticky rsp_err.
module ddr4_bank_arbiter
    import ddr4_arb_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 32,
    parameter int BURST_W   = 3,
    parameter int RSP_DEPTH = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [BURST_W-1:0]  m0_burstcount,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_write,
    input  logic                m0_read,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    input  logic [BURST_W-1:0]  m1_burstcount,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_write,
    input  logic                m1_read,
    input  logic [DATA_W/8-1:0] m1_byteenable,
`ifdef DDR4_ARB_PERF_EN
    output logic [31:0]         m0_grant_cnt,
    output logic [31:0]         m1_grant_cnt,
    output logic                rsp_err,
`endif
    input  logic                ddr_waitrequest,
    input  logic [DATA_W-1:0]   ddr_readdata,
    input  logic                ddr_readdatavalid,
    output logic [BURST_W-1:0]  ddr_burstcount,
    output logic [DATA_W-1:0]   ddr_writedata,
    output logic [ADDR_W-1:0]   ddr_address,
    output logic                ddr_write,
    output logic                ddr_read,
    output logic [DATA_W/8-1:0] ddr_byteenable
);
    arb_state_t           state;
    arb_id_t              rr_ptr;
    arb_id_t              lock_owner;
    logic [BURST_W-1:0]   remaining;
    logic [TAG_LEN_W-1:0] beat_cnt;

    logic                 fifo_full, fifo_empty, fifo_pop;
    rsp_tag_t             head_tag, push_tag;
    logic                 elig0, elig1, grant_valid, sel_write, sel_read;
    logic                 cmd_write, cmd_read, accept, rsp_beat;
    arb_id_t              grant_id;
    logic [BURST_W-1:0]   sel_bc_eff;

    assign elig0 = m0_write | (m0_read & ~fifo_full);
    assign elig1 = m1_write | (m1_read & ~fifo_full);

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == ARB_WLOCK) begin
            grant_valid = 1'b1;
            grant_id    = lock_owner;
        end else if (elig0 && elig1) begin
            grant_valid = 1'b1;
            grant_id    = ~rr_ptr;
        end else if (elig0) begin
            grant_valid = 1'b1;
        end else if (elig1) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign ddr_burstcount = grant_id ? m1_burstcount : m0_burstcount;
    assign ddr_writedata  = grant_id ? m1_writedata  : m0_writedata;
    assign ddr_address    = grant_id ? m1_address    : m0_address;
    assign ddr_byteenable = grant_id ? m1_byteenable : m0_byteenable;
    assign sel_bc_eff     = (ddr_burstcount == '0) ? BURST_W'(1) : ddr_burstcount;

    // A lock owner may only continue its write burst; reads wait for IDLE.
    assign sel_write = grant_id ? m1_write : m0_write;
    assign sel_read  = (state == ARB_IDLE) & (grant_id ? m1_read : m0_read);
    assign cmd_write = reset_reset_n & grant_valid & sel_write;
    assign cmd_read  = reset_reset_n & grant_valid & sel_read;
    assign ddr_write = cmd_write;
    assign ddr_read  = cmd_read;
    assign accept    = (cmd_write | cmd_read) & ~ddr_waitrequest;

    assign m0_waitrequest = ~(reset_reset_n & grant_valid & (grant_id == 1'b0)) | ddr_waitrequest;
    assign m1_waitrequest = ~(reset_reset_n & grant_valid & (grant_id == 1'b1)) | ddr_waitrequest;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= ARB_IDLE;
            rr_ptr     <= 1'b0;
            lock_owner <= 1'b0;
            remaining  <= '0;
        end else if (accept) begin
            if (state == ARB_IDLE) begin
                rr_ptr <= grant_id;
                if (cmd_write && sel_bc_eff > BURST_W'(1)) begin
                    state      <= ARB_WLOCK;
                    lock_owner <= grant_id;
                    remaining  <= sel_bc_eff - 1'b1;
                end
            end else begin
                remaining <= remaining - 1'b1;
                if (remaining == BURST_W'(1))
                    state <= ARB_IDLE;
            end
        end
    end

    assign push_tag.id  = grant_id;
    assign push_tag.len = TAG_LEN_W'(sel_bc_eff);

    ddr4_arb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .push     (accept & cmd_read),
        .push_tag (push_tag),
        .pop      (fifo_pop),
        .head     (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Beats with no outstanding tag are dropped rather than steered.
    assign rsp_beat         = reset_reset_n & ddr_readdatavalid & ~fifo_empty;
    assign fifo_pop         = rsp_beat & ((beat_cnt + 1'b1) == head_tag.len);
    assign m0_readdatavalid = rsp_beat & (head_tag.id == 1'b0);
    assign m1_readdatavalid = rsp_beat & (head_tag.id == 1'b1);
    assign m0_readdata      = ddr_readdata;
    assign m1_readdata      = ddr_readdata;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            beat_cnt <= '0;
        else if (rsp_beat)
            beat_cnt <= fifo_pop ? '0 : beat_cnt + 1'b1;
    end

`ifdef DDR4_ARB_PERF_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            m0_grant_cnt <= '0;
            m1_grant_cnt <= '0;
            rsp_err      <= 1'b0;
        end else begin
            if (accept && grant_id == 1'b0 && m0_grant_cnt != '1)
                m0_grant_cnt <= m0_grant_cnt + 1'b1;
            if (accept && grant_id == 1'b1 && m1_grant_cnt != '1)
                m1_grant_cnt <= m1_grant_cnt + 1'b1;
            if (ddr_readdatavalid && fifo_empty)
                rsp_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr4_bank_arbiter.sv
// tb/tb_ddr4_bank_arbiter.sv - directed self-checking bench for ddr4_bank_arbiter
module tb_ddr4_bank_arbiter;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 32;
    localparam int BW     = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic m0_wr, m0_rv, m1_wr, m1_rv;
    logic [DATA_W-1:0] m0_rd, m1_rd, m0_wd, m1_wd, ddr_rd, ddr_wd;
    logic [BW-1:0] m0_bc, m1_bc, ddr_bc;
    logic [ADDR_W-1:0] m0_addr, m1_addr, ddr_addr;
    logic m0_write, m0_read, m1_write, m1_read;
    logic [DATA_W/8-1:0] m0_be, m1_be, ddr_be;
    logic ddr_wait, ddr_rvalid, ddr_write, ddr_read;
`ifdef DDR4_ARB_PERF_EN
    logic [31:0] m0_gc, m1_gc;
    logic rsp_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ddr4_bank_arbiter dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .m0_waitrequest(m0_wr), .m0_readdata(m0_rd), .m0_readdatavalid(m0_rv),
        .m0_burstcount(m0_bc), .m0_writedata(m0_wd), .m0_address(m0_addr),
        .m0_write(m0_write), .m0_read(m0_read), .m0_byteenable(m0_be),
        .m1_waitrequest(m1_wr), .m1_readdata(m1_rd), .m1_readdatavalid(m1_rv),
        .m1_burstcount(m1_bc), .m1_writedata(m1_wd), .m1_address(m1_addr),
        .m1_write(m1_write), .m1_read(m1_read), .m1_byteenable(m1_be),
`ifdef DDR4_ARB_PERF_EN
        .m0_grant_cnt(m0_gc), .m1_grant_cnt(m1_gc), .rsp_err(rsp_err),
`endif
        .ddr_waitrequest(ddr_wait), .ddr_readdata(ddr_rd), .ddr_readdatavalid(ddr_rvalid),
        .ddr_burstcount(ddr_bc), .ddr_writedata(ddr_wd), .ddr_address(ddr_addr),
        .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_byteenable(ddr_be)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m0_write = 0; m0_read = 0; m1_write = 0; m1_read = 0;
        m0_bc = 1; m1_bc = 1; m0_wd = '0; m1_wd = '0; m0_addr = '0; m1_addr = '0;
        m0_be = '1; m1_be = '1; ddr_wait = 0; ddr_rd = '0; ddr_rvalid = 0;

        // Reset values even with live strobes
        @(negedge clk); m0_read = 1; ddr_rvalid = 1; #1;
        chk("rst_m0_wait", m0_wr, 1); chk("rst_m1_wait", m1_wr, 1);
        chk("rst_ddr_read", ddr_read, 0); chk("rst_m0_rvalid", m0_rv, 0);

        // 1: alternating single-beat reads, in-order responses
        @(negedge clk); rst_n = 1; ddr_rvalid = 0;
        m0_read = 1; m1_read = 1; m0_addr = 32'h100; m1_addr = 32'h200; #1;
        chk("t1_c1_m1_wait", m1_wr, 0); chk("t1_c1_m0_wait", m0_wr, 1);
        chk("t1_c1_addr", ddr_addr, 32'h200);
        @(negedge clk); #1;
        chk("t1_c2_m0_wait", m0_wr, 0); chk("t1_c2_addr", ddr_addr, 32'h100);
        @(negedge clk); #1;
        chk("t1_c3_m1_wait", m1_wr, 0);
        @(negedge clk); m0_read = 0; m1_read = 0; ddr_rvalid = 1; ddr_rd = 'hA0; #1;
        chk("t1_r0_m1_rv", m1_rv, 1); chk("t1_r0_m0_rv", m0_rv, 0);
        chk("t1_r0_data", m0_rd, 'hA0);
        @(negedge clk); ddr_rd = 'hA1; #1;
        chk("t1_r1_m0_rv", m0_rv, 1); chk("t1_r1_m1_rv", m1_rv, 0);
        @(negedge clk); ddr_rd = 'hA2; #1;
        chk("t1_r2_m1_rv", m1_rv, 1);
        @(negedge clk); #1;
        chk("t1_stray_m0", m0_rv, 0); chk("t1_stray_m1", m1_rv, 0);

        // 2+3: m0 write burst 4 locks out m1 read; stall on beat 2
        @(negedge clk); ddr_rvalid = 0;
        m0_write = 1; m0_bc = 4; m0_wd = 'hD0; m0_addr = 32'h300;
        m1_read = 1; m1_bc = 1; m1_addr = 32'h400; #1;
        chk("t2_b1_m0_wait", m0_wr, 0); chk("t2_b1_m1_wait", m1_wr, 1);
        chk("t2_b1_write", ddr_write, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); m0_wd = 'hD1; ddr_wait = 1; #1;
            chk("t3_stall_m0_wait", m0_wr, 1); chk("t3_stall_m1_wait", m1_wr, 1);
        end
        chk("t3_stall_wdata", ddr_wd, 'hD1);
        @(negedge clk); ddr_wait = 0; #1;
        chk("t3_b2_m0_wait", m0_wr, 0); chk("t3_b2_wdata", ddr_wd, 'hD1);
        @(negedge clk); m0_wd = 'hD2; #1;
        chk("t2_b3_m1_wait", m1_wr, 1);
        @(negedge clk); m0_wd = 'hD3; #1;
        chk("t2_b4_m0_wait", m0_wr, 0); chk("t2_b4_m1_wait", m1_wr, 1);
        @(negedge clk); m0_write = 0; #1;
        chk("t2_after_m1_wait", m1_wr, 0); chk("t2_after_read", ddr_read, 1);
        chk("t2_after_addr", ddr_addr, 32'h400);
        @(negedge clk); m1_read = 0; ddr_rvalid = 1; ddr_rd = 'hB0; #1;
        chk("t2_rsp_m1_rv", m1_rv, 1);

        // 4: 16 outstanding reads fill the tag FIFO
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); ddr_rvalid = 0; m0_read = 1; m0_bc = 2; #1;
            chk("t4_fill_m0_wait", m0_wr, 0);
        end
        @(negedge clk); m1_write = 1; m1_bc = 1; #1;
        chk("t4_full_m0_wait", m0_wr, 1); chk("t4_full_m1_wait", m1_wr, 0);
        @(negedge clk); m1_write = 0; ddr_rvalid = 1; ddr_rd = 'hE0; #1;
        chk("t4_rsp1_m0_rv", m0_rv, 1); chk("t4_rsp1_m0_wait", m0_wr, 1);
        @(negedge clk); ddr_rd = 'hE1; #1;
        chk("t4_rsp2_m0_rv", m0_rv, 1); chk("t4_pop_m0_wait", m0_wr, 1);
        @(negedge clk); ddr_rvalid = 0; #1;
        chk("t4_next_m0_wait", m0_wr, 0);
        @(negedge clk); m0_read = 0; rst_n = 0;
        @(negedge clk); rst_n = 1;

        // 5: reset mid-response drops the rest of the burst
        @(negedge clk); m1_read = 1; m1_bc = 3; m1_addr = 32'h500; #1;
        chk("t5_m1_wait", m1_wr, 0);
        @(negedge clk); m1_read = 0; ddr_rvalid = 1; ddr_rd = 'hC0; #1;
        chk("t5_r0_m1_rv", m1_rv, 1); chk("t5_r0_data", m1_rd, 'hC0);
        @(negedge clk); rst_n = 0; m1_read = 1; #1;
        chk("t5_rst_m1_wait", m1_wr, 1); chk("t5_rst_m1_rv", m1_rv, 0);
        chk("t5_rst_ddr_read", ddr_read, 0);
        @(negedge clk); rst_n = 1; m1_read = 0; #1;
        chk("t5_drop1_m1_rv", m1_rv, 0); chk("t5_drop1_m0_rv", m0_rv, 0);
        @(negedge clk); #1;
        chk("t5_drop2_m1_rv", m1_rv, 0);
        @(negedge clk); ddr_rvalid = 0; #1;
`ifdef DDR4_ARB_PERF_EN
        chk("t5_rsp_err", rsp_err, 1); chk("t5_m1_gcnt", m1_gc, 0);
`endif

        // burstcount 0 behaves as a single beat
        @(negedge clk); m0_read = 1; m0_bc = 0; #1;
        chk("bc0_m0_wait", m0_wr, 0);
        @(negedge clk); m0_read = 0; ddr_rvalid = 1; ddr_rd = 'hF0; #1;
        chk("bc0_r0_m0_rv", m0_rv, 1);
        @(negedge clk); #1;
        chk("bc0_r1_m0_rv", m0_rv, 0);
        @(negedge clk); ddr_rvalid = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
